// File: rtl/hsi_burst_scheduler.sv
// Round-robin owner of one HSI stream generator: grants a requester, programs a counted burst,
// sequences start/stop/hold around gen_done. Define HSI_SCHED_TIMEOUT_EN to add the RUN watchdog.
module hsi_burst_scheduler #(
  parameter int NCH          = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int MIN_GAP      = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] req_nsamples,
  input  logic              abort,
  input  logic              pause,
  input  logic              gen_done,
  output logic              gen_start,
  output logic              gen_stop,
  output logic              gen_hold,
  output logic [1:0]        gen_mode,
  output logic [15:0]       gen_nsamples,
  output logic [1:0]        gen_channel,
  output logic [NCH-1:0]    grant,
  output logic [NCH-1:0]    ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        dbg_state
);
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMAX = (SETUP_CYCLES > MIN_GAP) ? SETUP_CYCLES : MIN_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SETUP = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Handshake: req is a level held by the requester until ack; ack is a single-cycle pulse
  // and grant stays one-hot from SETUP through DRAIN.
  state_t          state;
  state_t          after_ack;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [15:0]     pick_ns;
  logic [CW-1:0]   phase_cnt;
  logic            wd_fire;

  // First set request at or after ptr; scanning downward lets the lowest offset win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NCH]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr) + k) % NCH);
      end
    end
  end

  assign pick_ns = req_nsamples[int'(pick_idx) * 16 +: 16];

  always_comb begin
    after_ack = S_GAP;
    if (MIN_GAP == 0) after_ack = (|req) ? S_ARB : S_IDLE;
  end

`ifdef HSI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] run_cnt;

  assign wd_fire = (state == S_RUN) && !pause && (run_cnt == TW'(TIMEOUT - 1));

  // SETUP always precedes RUN, so clearing there clears the count on RUN entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_SETUP) run_cnt <= '0;
      else if (state == S_RUN && !pause && run_cnt != TW'(TIMEOUT)) run_cnt <= run_cnt + 1'b1;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      phase_cnt    <= '0;
      gen_start    <= 1'b0;
      gen_stop     <= 1'b0;
      gen_hold     <= 1'b0;
      gen_mode     <= 2'b00;
      gen_nsamples <= '0;
      gen_channel  <= '0;
      grant        <= '0;
      ack          <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: if (|req && !gen_done) state <= S_ARB;
        S_ARB: begin
          if (!pick_valid) begin
            state <= S_IDLE;
          end else begin
            ptr       <= (pick_idx == IW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
            gen_mode  <= 2'b01;
            phase_cnt <= '0;
            if (pick_ns == 16'd0) begin
              ack[pick_idx] <= 1'b1;
              state         <= after_ack;
            end else begin
              grant[pick_idx] <= 1'b1;
              gen_nsamples    <= pick_ns;
              gen_channel     <= 2'(pick_idx);
              state           <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (phase_cnt == CW'(SETUP_CYCLES - 1)) begin
            gen_start <= 1'b1;
            gen_stop  <= 1'b0;
            gen_hold  <= 1'b0;
            state     <= S_RUN;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (gen_done) begin
            gen_start <= 1'b0;
            gen_stop  <= 1'b0;
            gen_hold  <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            // Once a stop is requested it sticks until done, and hold is kept low so it lands.
            gen_stop <= gen_stop | abort | wd_fire;
            gen_hold <= pause & ~abort & ~gen_stop & ~wd_fire;
          end
        end
        S_DRAIN: begin
          if (!gen_done) begin
            ack       <= grant;
            grant     <= '0;
            phase_cnt <= '0;
            state     <= after_ack;
          end
        end
        S_GAP: begin
          if (phase_cnt == CW'(MIN_GAP - 1)) state <= S_IDLE;
          else phase_cnt <= phase_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_hsi_burst_scheduler.sv
// Bench for hsi_burst_scheduler: scenario tasks drive requests and a hand-driven gen_done,
// expected grants are queued at stimulus time and popped when the grant appears.
module tb_hsi_burst_scheduler;
  localparam int NCH          = 4;
  localparam int SETUP_CYCLES = 2;
  localparam int MIN_GAP      = 4;
  localparam int TIMEOUT      = 16;
  localparam int BOUND        = 100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [16*NCH-1:0] req_nsamples = '0;
  logic              abort = 1'b0;
  logic              pause = 1'b0;
  logic              gen_done = 1'b0;
  logic              gen_start, gen_stop, gen_hold;
  logic [1:0]        gen_mode;
  logic [15:0]       gen_nsamples;
  logic [1:0]        gen_channel;
  logic [NCH-1:0]    grant, ack;
  logic              busy, timeout_err;
  logic [2:0]        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int model_ptr = 0;
  logic [17:0] exp_q[$];

  always #5 clock = ~clock;

  hsi_burst_scheduler #(
    .NCH(NCH), .SETUP_CYCLES(SETUP_CYCLES), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_nsamples(req_nsamples),
    .abort(abort), .pause(pause), .gen_done(gen_done),
    .gen_start(gen_start), .gen_stop(gen_stop), .gen_hold(gen_hold),
    .gen_mode(gen_mode), .gen_nsamples(gen_nsamples), .gen_channel(gen_channel),
    .grant(grant), .ack(ack), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] r, input int p);
    for (int k = 0; k < NCH; k++) if (r[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  // Model the arbiter decision for the current request set and queue the expected grant.
  task automatic expect_grant(output int p);
    p = rr_pick(req, model_ptr);
    model_ptr = (p + 1) % NCH;
    exp_q.push_back({2'(p), req_nsamples[16*p +: 16]});
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (grant === '0 && cyc < BOUND) begin tick(); cyc++; end
    if (cyc >= BOUND) begin miscompares++; $display("FAIL wait_grant: no grant within %0d cycles", BOUND); end
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (gen_start !== 1'b1 && cyc < BOUND) begin tick(); cyc++; end
    if (cyc >= BOUND) begin miscompares++; $display("FAIL wait_start: no gen_start within %0d cycles", BOUND); end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (dbg_state !== ST_IDLE && cyc < BOUND) begin tick(); cyc++; end
    if (cyc >= BOUND) begin miscompares++; $display("FAIL wait_idle: state %0d after %0d cycles", dbg_state, BOUND); end
  endtask

  // Generator stand-in: run a while, raise done for one cycle, then wait for the ack pulse.
  task automatic complete_burst(input int run_cycles, input bit drop, output logic [NCH-1:0] ack_seen);
    ack_seen = '0;
    repeat (run_cycles) tick();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    for (int i = 0; i < 20 && ack_seen == '0; i++) begin tick(); ack_seen = ack; end
    if (drop) req = req & ~ack_seen;
  endtask

  task automatic pop_and_compare(input string name);
    logic [17:0] exp_v;
    logic [17:0] got_v;
    got_v = {gen_channel, gen_nsamples};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++; $display("FAIL %s: grant with empty expected queue, got %h", name, got_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (got_v !== exp_v) begin miscompares++; $display("FAIL %s: got ch/ns %h expected %h", name, got_v, exp_v); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({gen_start, gen_stop, gen_hold, gen_mode, gen_nsamples, gen_channel, grant, ack, busy, timeout_err} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got start=%b stop=%b hold=%b mode=%b ns=%0d ch=%0d grant=%b ack=%b busy=%b to=%b, expected all 0",
        gen_start, gen_stop, gen_hold, gen_mode, gen_nsamples, gen_channel, grant, ack, busy, timeout_err);
    end
    vectors++;
    if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset_n = 1'b1;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] a;
    logic [NCH-1:0] oh;
    int cyc;
    int p;
    wait_idle();
    for (int i = 0; i < NCH; i++) req_nsamples[16*i +: 16] = 16'd3;
    req = '1;
    for (int b = 0; b < 5; b++) begin
      expect_grant(p);
      oh = '0;
      oh[p] = 1'b1;
      wait_grant(cyc);
      if (b > 0) begin
        vectors++;
        if (cyc < MIN_GAP + 1) begin miscompares++; $display("FAIL rr_gap: got %0d cycles ack->grant, expected >= %0d", cyc, MIN_GAP + 1); end
      end
      pop_and_compare("rr_config");
      vectors++;
      if (grant !== oh) begin miscompares++; $display("FAIL rr_grant: burst %0d got %b expected %b", b, grant, oh); end
      wait_start(cyc);
      complete_burst(1, 1'b0, a);
      vectors++;
      if (a !== oh) begin miscompares++; $display("FAIL rr_ack: burst %0d got %b expected %b", b, a, oh); end
    end
    req = '0;
  endtask

  task automatic test_single_burst();
    int cyc;
    int p;
    wait_idle();
    req_nsamples[16*2 +: 16] = 16'd5;
    req = 4'b0100;
    expect_grant(p);
    tick();
    vectors++;
    if (dbg_state !== ST_ARB) begin miscompares++; $display("FAIL single_arb: got state %0d expected %0d", dbg_state, ST_ARB); end
    tick();
    vectors++;
    if (grant !== 4'b0100 || gen_start !== 1'b0) begin miscompares++; $display("FAIL single_setup: got grant=%b start=%b expected 0100/0", grant, gen_start); end
    pop_and_compare("single_config");
    vectors++;
    if (gen_mode !== 2'b01) begin miscompares++; $display("FAIL single_mode: got %b expected 01", gen_mode); end
    wait_start(cyc);
    vectors++;
    if (cyc + 1 !== SETUP_CYCLES + 1) begin miscompares++; $display("FAIL single_latency: got %0d cycles ARB->start expected %0d", cyc + 1, SETUP_CYCLES + 1); end
    repeat (3) tick();
    gen_done = 1'b1;
    tick();
    vectors++;
    if (gen_start !== 1'b0 || dbg_state !== ST_DRAIN) begin miscompares++; $display("FAIL single_done: got start=%b state=%0d expected 0/%0d", gen_start, dbg_state, ST_DRAIN); end
    gen_done = 1'b0;
    tick();
    vectors++;
    if (ack !== 4'b0100 || grant !== '0) begin miscompares++; $display("FAIL single_ack: got ack=%b grant=%b expected 0100/0000", ack, grant); end
    req = '0;
    tick();
    vectors++;
    if (ack !== '0) begin miscompares++; $display("FAIL single_ack_pulse: got ack=%b expected 0000", ack); end
  endtask

  task automatic test_zero_samples();
    bit bad = 1'b0;
    int p;
    int got_idx = -1;
    wait_idle();
    req_nsamples[16*1 +: 16] = 16'd0;
    req = 4'b0010;
    expect_grant(p);
    tick();
    tick();
    for (int i = 0; i < NCH; i++) if (ack[i]) got_idx = i;
    vectors++;
    if (ack !== 4'b0010 || grant !== '0 || dbg_state !== ST_GAP) begin
      miscompares++; $display("FAIL zero_ack: got ack=%b grant=%b state=%0d expected 0010/0000/%0d", ack, grant, dbg_state, ST_GAP);
    end
    vectors++;
    if (exp_q.size() == 0 || {2'(got_idx), 16'd0} !== exp_q.pop_front()) begin miscompares++; $display("FAIL zero_idx: got ack index %0d expected %0d", got_idx, p); end
    req = '0;
    for (int i = 0; i < 10; i++) begin tick(); if (gen_start !== 1'b0 || grant !== '0) bad = 1'b1; end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL zero_no_start: got gen_start/grant activity expected none"); end
  endtask

  task automatic test_abort();
    logic [NCH-1:0] a;
    int cyc;
    int p;
    wait_idle();
    req_nsamples[16*3 +: 16] = 16'd7;
    req = 4'b1000;
    expect_grant(p);
    wait_grant(cyc);
    pop_and_compare("abort_config");
    wait_start(cyc);
    tick(); tick();
    abort = 1'b1;
    pause = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (gen_stop !== 1'b1 || gen_hold !== 1'b0) begin miscompares++; $display("FAIL abort_stop: got stop=%b hold=%b expected 1/0", gen_stop, gen_hold); end
    tick(); tick();
    vectors++;
    if (gen_stop !== 1'b1 || gen_hold !== 1'b0) begin miscompares++; $display("FAIL abort_sticky: got stop=%b hold=%b expected 1/0", gen_stop, gen_hold); end
    pause = 1'b0;
    gen_done = 1'b1;
    tick();
    vectors++;
    if (gen_stop !== 1'b0 || gen_start !== 1'b0) begin miscompares++; $display("FAIL abort_release: got stop=%b start=%b expected 0/0", gen_stop, gen_start); end
    gen_done = 1'b0;
    tick();
    a = ack;
    vectors++;
    if (a !== 4'b1000) begin miscompares++; $display("FAIL abort_ack: got %b expected 1000", a); end
    req = '0;
  endtask

  task automatic test_pause();
    logic [NCH-1:0] a;
    int cyc;
    int p;
    int hold_cnt = 0;
    bit cfg_bad = 1'b0;
    wait_idle();
    req_nsamples[16*0 +: 16] = 16'd9;
    req = 4'b0001;
    expect_grant(p);
    wait_grant(cyc);
    pop_and_compare("pause_config");
    wait_start(cyc);
    tick(); tick();
    pause = 1'b1;
    vectors++;
    if (gen_hold !== 1'b0) begin miscompares++; $display("FAIL pause_lag: got hold=%b before edge expected 0", gen_hold); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gen_hold === 1'b1) hold_cnt++;
      if ({gen_channel, gen_nsamples, gen_mode, grant} !== {2'd0, 16'd9, 2'b01, 4'b0001}) cfg_bad = 1'b1;
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (gen_hold === 1'b1) hold_cnt++; end
    vectors++;
    if (hold_cnt !== 20) begin miscompares++; $display("FAIL pause_hold: got %0d hold cycles expected 20", hold_cnt); end
    vectors++;
    if (cfg_bad) begin miscompares++; $display("FAIL pause_config_hold: got config change while granted expected none"); end
    complete_burst(0, 1'b1, a);
    vectors++;
    if (a !== 4'b0001) begin miscompares++; $display("FAIL pause_ack: got %b expected 0001", a); end
`ifndef HSI_SCHED_TIMEOUT_EN
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL no_watchdog: got timeout_err=%b expected 0", timeout_err); end
`endif
  endtask

  task automatic test_done_stuck();
    logic [NCH-1:0] a;
    int cyc;
    int p;
    wait_idle();
    gen_done = 1'b1;
    req_nsamples[16*1 +: 16] = 16'd3;
    req = 4'b0010;
    repeat (5) tick();
    vectors++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL done_stuck: got state=%0d busy=%b expected %0d/0", dbg_state, busy, ST_IDLE); end
    gen_done = 1'b0;
    expect_grant(p);
    wait_grant(cyc);
    pop_and_compare("stuck_config");
    wait_start(cyc);
    req = '0;
    complete_burst(2, 1'b1, a);
    vectors++;
    if (a !== 4'b0010) begin miscompares++; $display("FAIL stuck_ack: got %b expected 0010 (req dropped while granted)", a); end
  endtask

`ifdef HSI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [NCH-1:0] a;
    int cyc;
    int p;
    wait_idle();
    req_nsamples[16*2 +: 16] = 16'd5;
    req = 4'b0100;
    expect_grant(p);
    wait_grant(cyc);
    pop_and_compare("timeout_config");
    wait_start(cyc);
    cyc = 0;
    while (gen_stop !== 1'b1 && cyc < BOUND) begin tick(); cyc++; end
    vectors++;
    if (cyc !== TIMEOUT) begin miscompares++; $display("FAIL timeout_cycle: got stop after %0d cycles expected %0d", cyc, TIMEOUT); end
    vectors++;
    if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_flag: got %b expected 1", timeout_err); end
    complete_burst(0, 1'b1, a);
    vectors++;
    if (a !== 4'b0100 || timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_ack: got ack=%b err=%b expected 0100/1", a, timeout_err); end
  endtask
`endif

  task automatic test_reset_mid_run();
    logic [NCH-1:0] a;
    int cyc;
    int p;
    wait_idle();
    req_nsamples[16*2 +: 16] = 16'd4;
    req = 4'b0100;
    expect_grant(p);
    wait_grant(cyc);
    pop_and_compare("midrun_config");
    wait_start(cyc);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({gen_start, grant, busy, gen_mode, gen_nsamples} !== '0) begin
      miscompares++; $display("FAIL reset_async: got start=%b grant=%b busy=%b mode=%b ns=%0d expected all 0", gen_start, grant, busy, gen_mode, gen_nsamples);
    end
    req = '0;
    tick(); tick();
    reset_n = 1'b1;
    model_ptr = 0;
    tick();
    for (int i = 0; i < NCH; i++) req_nsamples[16*i +: 16] = 16'd2;
    req = '1;
    expect_grant(p);
    wait_grant(cyc);
    vectors++;
    if (grant !== 4'b0001) begin miscompares++; $display("FAIL reset_first_grant: got %b expected 0001", grant); end
    pop_and_compare("post_reset_config");
    req = '0;
    wait_start(cyc);
    complete_burst(1, 1'b1, a);
    vectors++;
    if (a !== 4'b0001) begin miscompares++; $display("FAIL post_reset_ack: got %b expected 0001", a); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_zero_samples();
    test_abort();
    test_pause();
    test_done_stuck();
`ifdef HSI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
